// File: rtl/load_store_unit.sv
// Load/store unit: takes one load or store at a time, runs the data-memory
// request handshake, formats store byte lanes and load results, and
// broadcasts completed loads on the CDB with their ROB tag.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  flush,
  output logic [1:0]            mem_rw_flag,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_mask,
  input  logic                  mem_free,
  input  logic                  mem_read_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  cdb_valid,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic [31:0]           cdb_data,
  output logic                  store_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            mask_q;
  logic                  flushed_q;
  logic                  cdb_valid_q;
  logic [TAG_WIDTH-1:0]  cdb_tag_q;
  logic [31:0]           cdb_data_q;
  logic                  store_done_q;

  logic                  accept;
  logic [3:0]            st_mask;
  logic [31:0]           st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_result;

  assign accept     = req_valid && req_ready;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_mask   = mask_q;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_data   = cdb_data_q;
  assign store_done = store_done_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a flushed load in ISSUE aborts before touching memory
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: begin
        if (!is_store_q && flush) state_d = S_IDLE;
        else if (mem_free)        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (is_store_q) begin
          if (mem_free) state_d = S_IDLE;
        end else if (mem_read_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs: ready only when idle, start flag only for one issue cycle
  always_comb begin
    req_ready   = (state_q == S_IDLE) && !flush;
    mem_rw_flag = '0;
    if ((state_q == S_ISSUE) && mem_free && (is_store_q || !flush))
      mem_rw_flag = {!is_store_q, is_store_q};
  end

  // Store lane formatting from the incoming request
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = req_data;
    case (req_funct3)
      3'b000: begin
        st_mask  = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_data[7:0]}};
      end
      3'b001: begin
        st_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction and extension; unknown widths return the whole word
  always_comb begin
    ld_byte   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_result = mem_rdata;
    case (funct3_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_result = {24'h000000, ld_byte};
      3'b101:  ld_result = {16'h0000, ld_half};
      default: ld_result = mem_rdata;
    endcase
  end

  // Request latch, flush tracking for in-flight loads, completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      tag_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      flushed_q    <= 1'b0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      store_done_q <= 1'b0;
    end else begin
      cdb_valid_q  <= 1'b0;
      store_done_q <= 1'b0;
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        tag_q      <= req_tag;
        addr_q     <= req_addr;
        wdata_q    <= st_wdata;
        mask_q     <= st_mask;
        flushed_q  <= 1'b0;
      end
      if ((state_q == S_WAIT) && !is_store_q) begin
        if (flush) flushed_q <= 1'b1;
        if (mem_read_valid) begin
          if (!(flushed_q || flush)) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= tag_q;
            cdb_data_q  <= ld_result;
          end
        end
      end
      if ((state_q == S_WAIT) && is_store_q && mem_free)
        store_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a two-cycle data memory model, a table of
// load/store vectors with hand-computed results, and directed sequences for
// memory stall, flush, back-to-back issue and mid-operation reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_tag;
  logic        flush;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_free;
  logic        mem_read_valid;
  logic [31:0] mem_rdata;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        store_done;

  logic        stall;
  logic        free_q;
  logic [1:0]  busy_cnt;
  logic        op_st;
  logic [31:0] mem [0:63];

  int errors = 0;
  int checks = 0;
  int rw_cnt = 0;
  int both_seen = 0;
  int acc_cnt = 0;

  load_store_unit #(.ADDR_WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .req_tag(req_tag), .flush(flush),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_free(mem_free), .mem_read_valid(mem_read_valid),
    .mem_rdata(mem_rdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .store_done(store_done)
  );

  always #5 clk = ~clk;

  // Memory: samples rw_flag while free, busy two cycles, completes using the
  // address/mask/data held by the unit at completion time
  assign mem_free = free_q && !stall;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q         <= 1'b1;
      busy_cnt       <= 2'd0;
      op_st          <= 1'b0;
      mem_read_valid <= 1'b0;
      mem_rdata      <= '0;
    end else begin
      mem_read_valid <= 1'b0;
      if (busy_cnt == 2'd0) begin
        if (mem_free && (mem_rw_flag != 2'b00)) begin
          free_q   <= 1'b0;
          busy_cnt <= 2'd2;
          op_st    <= mem_rw_flag[0];
        end
      end else if (busy_cnt == 2'd2) begin
        busy_cnt <= 2'd1;
      end else begin
        busy_cnt <= 2'd0;
        free_q   <= 1'b1;
        if (op_st) begin
          for (int b = 0; b < 4; b++)
            if (mem_mask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          mem_read_valid <= 1'b1;
          mem_rdata      <= mem[mem_addr[7:2]];
        end
      end
    end
  end

  // Protocol monitor: start pulses, illegal 2'b11, accepted requests
  always @(negedge clk) begin
    if (mem_rw_flag != 2'b00) rw_cnt <= rw_cnt + 1;
    if (mem_rw_flag == 2'b11) both_seen <= both_seen + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
    logic [3:0]  emask;
    logic [31:0] ewdata;
    logic [31:0] ecdb;
  } vec_t;

  vec_t vecs [22];

  task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] t);
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_data     = d;
    req_tag      = t;
  endtask

  // One full transaction from an idle unit, checking lanes, latency and result
  task automatic do_op(input vec_t v);
    int n;
    int r0;
    bit done;
    @(negedge clk);
    set_req(v.st, v.f3, v.addr, v.data, v.tag);
    req_valid = 1'b1;
    chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
    r0 = rw_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mem_addr", mem_addr, v.addr);
    if (v.st) begin
      chk("mem_mask", {28'd0, mem_mask}, {28'd0, v.emask});
      chk("mem_wdata", mem_wdata, v.ewdata);
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (cdb_valid || store_done) done = 1'b1;
    end
    chk("latency", n, 4);
    if (v.st) begin
      chk("store_done", {31'd0, store_done}, 32'd1);
      chk("no_cdb_on_store", {31'd0, cdb_valid}, 32'd0);
    end else begin
      chk("cdb_data", cdb_data, v.ecdb);
      chk("cdb_tag", {28'd0, cdb_tag}, {28'd0, v.tag});
    end
    chk("ready_at_done", {31'd0, req_ready}, 32'd1);
    chk("rw_pulses", rw_cnt - r0, 1);
    @(posedge clk); #1;
    chk("pulse_cleared", {30'd0, cdb_valid, store_done}, 32'd0);
  endtask

  initial begin
    int n;
    int r0;
    int a0;
    int cdb_seen;
    bit done;
    vec_t bb [3];
    vec_t v;

    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'h1, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        4'h2, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'b010, 32'h10, 32'h11223344, 4'h3, 4'hF, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 3'b000, 32'h13, 32'h00000080, 4'h4, 4'h8, 32'h80808080, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h10, 32'h0,        4'h5, 4'h0, 32'h0,        32'h80223344};
    vecs[5]  = '{1'b0, 3'b000, 32'h13, 32'h0,        4'h6, 4'h0, 32'h0,        32'hFFFFFF80};
    vecs[6]  = '{1'b0, 3'b100, 32'h13, 32'h0,        4'h7, 4'h0, 32'h0,        32'h00000080};
    vecs[7]  = '{1'b0, 3'b000, 32'h12, 32'h0,        4'h8, 4'h0, 32'h0,        32'h00000022};
    vecs[8]  = '{1'b0, 3'b101, 32'h10, 32'h0,        4'h9, 4'h0, 32'h0,        32'h00003344};
    vecs[9]  = '{1'b1, 3'b010, 32'h20, 32'h00007FFF, 4'hA, 4'hF, 32'h00007FFF, 32'h0};
    vecs[10] = '{1'b1, 3'b001, 32'h22, 32'hABCD8001, 4'hB, 4'hC, 32'h80018001, 32'h0};
    vecs[11] = '{1'b0, 3'b001, 32'h22, 32'h0,        4'hC, 4'h0, 32'h0,        32'hFFFF8001};
    vecs[12] = '{1'b0, 3'b101, 32'h22, 32'h0,        4'hD, 4'h0, 32'h0,        32'h00008001};
    vecs[13] = '{1'b0, 3'b001, 32'h20, 32'h0,        4'hE, 4'h0, 32'h0,        32'h00007FFF};
    vecs[14] = '{1'b0, 3'b001, 32'h23, 32'h0,        4'hF, 4'h0, 32'h0,        32'hFFFF8001};
    vecs[15] = '{1'b0, 3'b010, 32'h21, 32'h0,        4'h0, 4'h0, 32'h0,        32'h80017FFF};
    vecs[16] = '{1'b0, 3'b011, 32'h20, 32'h0,        4'h1, 4'h0, 32'h0,        32'h80017FFF};
    vecs[17] = '{1'b1, 3'b001, 32'h20, 32'h00001234, 4'h2, 4'h3, 32'h12341234, 32'h0};
    vecs[18] = '{1'b0, 3'b010, 32'h20, 32'h0,        4'h3, 4'h0, 32'h0,        32'h80011234};
    vecs[19] = '{1'b1, 3'b000, 32'h21, 32'h000000C5, 4'h4, 4'h2, 32'hC5C5C5C5, 32'h0};
    vecs[20] = '{1'b0, 3'b100, 32'h21, 32'h0,        4'h5, 4'h0, 32'h0,        32'h000000C5};
    vecs[21] = '{1'b0, 3'b000, 32'h21, 32'h0,        4'h6, 4'h0, 32'h0,        32'hFFFFFFC5};

    rst = 1'b1;
    req_valid = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    set_req(1'b0, 3'b010, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_mask", {28'd0, mem_mask}, 32'h0);
    chk("rst_cdb", {cdb_valid, cdb_tag, store_done, 26'd0}, 32'h0);
    chk("rst_cdb_data", cdb_data, 32'h0);
    chk("rst_rw_flag", {30'd0, mem_rw_flag}, 32'h0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) do_op(vecs[i]);

    // Memory busy for three issue cycles: no start flag until it frees up
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h10, 32'h0, 4'h9);
    req_valid = 1'b1;
    stall = 1'b1;
    r0 = rw_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("stall_rw0", {30'd0, mem_rw_flag}, 32'h0);
    @(posedge clk); #1;
    chk("stall_rw1", {30'd0, mem_rw_flag}, 32'h0);
    @(posedge clk); #1;
    chk("stall_rw2", {30'd0, mem_rw_flag}, 32'h0);
    stall = 1'b0;
    #1;
    chk("stall_release_rw", {30'd0, mem_rw_flag}, 32'h2);
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (cdb_valid) done = 1'b1;
    end
    chk("stall_done", {31'd0, done}, 32'd1);
    chk("stall_data", cdb_data, 32'h80223344);
    chk("stall_rw_once", rw_cnt - r0, 1);

    // Flush while a load waits for memory: completion is swallowed
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h20, 32'h0, 4'h7);
    req_valid = 1'b1;
    r0 = rw_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n = 0;
    cdb_seen = 0;
    chk("wflush_busy", {31'd0, req_ready}, 32'd0);
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (cdb_valid) cdb_seen++;
    end
    chk("wflush_ready_delay", n, 2);
    repeat (3) begin
      @(posedge clk); #1;
      if (cdb_valid) cdb_seen++;
    end
    chk("wflush_no_cdb", cdb_seen, 0);
    chk("wflush_rw_once", rw_cnt - r0, 1);

    // Flush during ISSUE: load aborted without a start flag
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h10, 32'h0, 4'h6);
    req_valid = 1'b1;
    r0 = rw_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("iflush_rw", {30'd0, mem_rw_flag}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("iflush_ready", {31'd0, req_ready}, 32'd1);
    cdb_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cdb_valid) cdb_seen++;
    end
    chk("iflush_no_cdb", cdb_seen, 0);
    chk("iflush_no_rw", rw_cnt - r0, 0);
    chk("iflush_mem_free", {31'd0, mem_free}, 32'd1);

    // Store with flush held throughout still completes
    @(negedge clk);
    set_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 4'h2);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (store_done) done = 1'b1;
    end
    flush = 1'b0;
    chk("sflush_latency", n, 4);
    v = '{1'b0, 3'b010, 32'h30, 32'h0, 4'h3, 4'h0, 32'h0, 32'hCAFEF00D};
    do_op(v);

    // Back-to-back with req_valid held high across all three operations
    bb[0] = '{1'b0, 3'b010, 32'h10, 32'h0,        4'h3, 4'h0, 32'h0, 32'h80223344};
    bb[1] = '{1'b1, 3'b010, 32'h40, 32'h55AA55AA, 4'h4, 4'hF, 32'h0, 32'h0};
    bb[2] = '{1'b0, 3'b010, 32'h40, 32'h0,        4'h5, 4'h0, 32'h0, 32'h55AA55AA};
    @(posedge clk); #1;
    a0 = acc_cnt;
    set_req(bb[0].st, bb[0].f3, bb[0].addr, bb[0].data, bb[0].tag);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      done = 1'b0;
      while (!done && n < 20) begin
        @(posedge clk); #1;
        n++;
        if (cdb_valid || store_done) done = 1'b1;
      end
      chk("b2b_latency", n, 5);
      if (bb[k].st) begin
        chk("b2b_store_done", {31'd0, store_done}, 32'd1);
      end else begin
        chk("b2b_cdb_data", cdb_data, bb[k].ecdb);
        chk("b2b_cdb_tag", {28'd0, cdb_tag}, {28'd0, bb[k].tag});
      end
      if (k < 2) set_req(bb[k+1].st, bb[k+1].f3, bb[k+1].addr, bb[k+1].data, bb[k+1].tag);
      else req_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_accepts", acc_cnt - a0, 3);
    chk("rw_never_both", both_seen, 0);

    // Reset in the middle of a load
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h10, 32'h0, 4'h8);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_ready", {31'd0, req_ready}, 32'd1);
    chk("mrst_state", {mem_mask, mem_rw_flag, cdb_valid, store_done, 24'd0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cdb_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cdb_valid) cdb_seen++;
    end
    chk("mrst_no_cdb", cdb_seen, 0);
    v = '{1'b0, 3'b010, 32'h10, 32'h0, 4'hA, 4'h0, 32'h0, 32'h80223344};
    do_op(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
